// File: rtl/hex_display_ctrl_pkg.sv
// Shared constants for the hex display controller: blank glyph,
// FSM state encodings and the 16-entry active-low glyph table.
package hex_display_ctrl_pkg;

    // All segments off (active-low)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_BLANK     = 2'd0,
        ST_SHOW      = 2'd1,
        ST_BLINK_OFF = 2'd2
    } state_t;

    // Active-low glyphs, bit order g..a; index = hex nibble
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Bus between a status source and the hex display controller.
// master: drives LOAD/VALUE/CLR/BLINK, reads HEX/SHOWN. slave: controller.
interface hex_display_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  LOAD;
    logic [4*DIGITS-1:0]   VALUE;
    logic                  CLR;
    logic                  BLINK;
    logic [7*DIGITS-1:0]   HEX;
    logic                  SHOWN;

    modport master (
        output LOAD, VALUE, CLR, BLINK,
        input  HEX, SHOWN
    );

    modport slave (
        input  LOAD, VALUE, CLR, BLINK,
        output HEX, SHOWN
    );
endinterface

// File: rtl/hex_display_ctrl_seg_decode.sv
// hex_seg_decode: combinational 4-bit nibble -> 7-bit active-low glyph.
// Ports: nib (in, 4), seg (out, 7, bit order g..a).
module hex_seg_decode
    import hex_display_ctrl_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = GLYPH[nib];

endmodule

// File: rtl/hex_display_ctrl.sv
// Registered N-digit hex display controller (active-low 7-seg).
// Ports: CLK, RST_N (async, active-low), bus (slave modport:
//   LOAD, VALUE, CLR, BLINK in; HEX, SHOWN out, both registered).
// Optional macro LZB_EN: leading-zero blanking while showing.
module hex_display_ctrl
    import hex_display_ctrl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25000000
)(
    input  logic              CLK,
    input  logic              RST_N,
    hex_display_ctrl_if.slave bus
);

    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7*DIGITS-1:0]   hex_q, hex_d;
    logic                  shown_q, shown_d;

    logic [7*DIGITS-1:0]   glyph;
    logic [DIGITS-1:0]     lit;
    logic                  wrap;
    logic [CW-1:0]         cnt_adv;

    for (genvar d = 0; d < DIGITS; d++) begin : g_dec
        hex_seg_decode u_dec (
            .nib (value_q[4*d +: 4]),
            .seg (glyph[7*d +: 7])
        );
    end

`ifdef LZB_EN
    // A digit is lit once any digit at or above it is nonzero;
    // digit 0 is always lit so zero reads as a single "0".
    always_comb begin
        logic seen;
        lit  = '1;
        seen = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            seen   = seen | (|value_q[4*d +: 4]);
            lit[d] = seen;
        end
    end
`else
    assign lit = '1;
`endif

    assign wrap    = bus.BLINK && (cnt_q == CNT_MAX);
    assign cnt_adv = wrap ? '0 : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        if (bus.CLR) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
        end else if (bus.LOAD) begin
            value_d = bus.VALUE;
            state_d = ST_SHOW;
            // Reload in SHOW keeps the blink cadence; from any other
            // state the visible phase restarts from zero.
            if (state_q == ST_SHOW && bus.BLINK) begin
                cnt_d = cnt_adv;
            end else begin
                cnt_d = '0;
            end
        end else begin
            unique case (state_q)
                ST_BLANK: begin
                    cnt_d = '0;
                end
                ST_SHOW: begin
                    if (!bus.BLINK) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_adv;
                        if (wrap) state_d = ST_BLINK_OFF;
                    end
                end
                ST_BLINK_OFF: begin
                    if (!bus.BLINK) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_adv;
                        if (wrap) state_d = ST_SHOW;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        hex_d   = {(7*DIGITS){1'b1}};
        shown_d = (state_q != ST_BLANK);
        if (state_q == ST_SHOW) begin
            for (int d = 0; d < DIGITS; d++) begin
                hex_d[7*d +: 7] = lit[d] ? glyph[7*d +: 7] : SEG_OFF;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_BLANK;
            value_q <= '0;
            cnt_q   <= '0;
            hex_q   <= {(7*DIGITS){1'b1}};
            shown_q <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            shown_q <= shown_d;
        end
    end

    assign bus.HEX   = hex_q;
    assign bus.SHOWN = shown_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl (DIGITS=4, BLINK_DIV=4).
// Table of load/clear vectors plus blink, latency and reset sequences.
module tb_hex_display_ctrl;

    localparam logic [27:0] ONES = 28'hFFFFFFF;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    hex_display_ctrl_if #(.DIGITS(4)) bus ();

    hex_display_ctrl #(
        .DIGITS    (4),
        .BLINK_DIV (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic        clr;
        logic [27:0] hex;
        logic        shown;
    } vec_t;

    function automatic logic [6:0] gl(input logic [3:0] n);
        case (n)
            4'h0: gl = 7'b1000000;
            4'h1: gl = 7'b1111001;
            4'h2: gl = 7'b0100100;
            4'h3: gl = 7'b0110000;
            4'h4: gl = 7'b0011001;
            4'h5: gl = 7'b0010010;
            4'h6: gl = 7'b0000010;
            4'h7: gl = 7'b1111000;
            4'h8: gl = 7'b0000000;
            4'h9: gl = 7'b0010000;
            4'hA: gl = 7'b0001000;
            4'hB: gl = 7'b0000011;
            4'hC: gl = 7'b1000110;
            4'hD: gl = 7'b0100001;
            4'hE: gl = 7'b0000110;
            default: gl = 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] model(input logic [15:0] v);
        logic [27:0] r;
        logic        nz;
        r  = '0;
        nz = 1'b0;
        for (int d = 3; d >= 0; d--) begin
            nz = nz | (v[4*d +: 4] != 4'h0);
            r[7*d +: 7] = gl(v[4*d +: 4]);
`ifdef LZB_EN
            if (!nz && d != 0) r[7*d +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [27:0] act,
                       input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [15:0] v,
                         input logic clr);
        bus.LOAD  = ld;
        bus.VALUE = v;
        bus.CLR   = clr;
    endtask

    vec_t vecs [8];
    logic [27:0] m12af;
    logic [27:0] mbeef;

    initial begin
        m12af = {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110};
        mbeef = model(16'hBEEF);
        vecs[0] = '{1'b1, 16'h12AF, 1'b0, m12af,          1'b1};
        vecs[1] = '{1'b1, 16'h0030, 1'b0, model(16'h0030), 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, ONES,           1'b0};
        vecs[3] = '{1'b1, 16'h5555, 1'b1, ONES,           1'b0};
        vecs[4] = '{1'b1, 16'h0000, 1'b0, model(16'h0000), 1'b1};
        vecs[5] = '{1'b1, 16'hBEEF, 1'b0, mbeef,          1'b1};
        vecs[6] = '{1'b1, 16'h8001, 1'b0, model(16'h8001), 1'b1};
        vecs[7] = '{1'b1, 16'hC3D9, 1'b0, model(16'hC3D9), 1'b1};

        bus.BLINK = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        repeat (3) cyc();
        RST_N = 1'b1;
        chk("reset_hex", bus.HEX, ONES);
        chk("reset_shown", 28'(bus.SHOWN), 28'd0);
        repeat (100) cyc();
        chk("idle_hex", bus.HEX, ONES);
        chk("idle_shown", 28'(bus.SHOWN), 28'd0);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].ld, vecs[i].val, vecs[i].clr);
            cyc();
            drive(1'b0, 16'h0, 1'b0);
            cyc();
            chk($sformatf("vec%0d_hex", i), bus.HEX, vecs[i].hex);
            chk($sformatf("vec%0d_shown", i), 28'(bus.SHOWN),
                28'(vecs[i].shown));
        end

        // One-cycle output latency after LOAD
        drive(1'b0, 16'h0, 1'b1);
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        cyc();
        drive(1'b1, 16'h12AF, 1'b0);
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        chk("lat_edge_k", bus.HEX, ONES);
        cyc();
        chk("lat_edge_k1", bus.HEX, m12af);
        chk("lat_shown", 28'(bus.SHOWN), 28'd1);

        // Blink cadence and LOAD during the off phase
        drive(1'b0, 16'h0, 1'b1);
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        cyc();
        drive(1'b1, 16'h12AF, 1'b0);
        bus.BLINK = 1'b1;
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk($sformatf("blink_%0d", i), bus.HEX,
                (((i - 1) / 4) % 2 == 0) ? m12af : ONES);
        end
        drive(1'b1, 16'hBEEF, 1'b0);
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        chk("offload_edge", bus.HEX, ONES);
        chk("offload_shown", 28'(bus.SHOWN), 28'd1);
        for (int j = 1; j <= 5; j++) begin
            cyc();
            chk($sformatf("relit_%0d", j), bus.HEX,
                (j <= 4) ? mbeef : ONES);
        end
        bus.BLINK = 1'b0;
        cyc();
        cyc();
        chk("unblink", bus.HEX, mbeef);
        repeat (10) cyc();
        chk("steady", bus.HEX, mbeef);

        // Async reset mid-blink, then a full first phase
        bus.BLINK = 1'b1;
        drive(1'b1, 16'h8001, 1'b0);
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        cyc();
        cyc();
        RST_N = 1'b0;
        #2;
        chk("async_hex", bus.HEX, ONES);
        chk("async_shown", 28'(bus.SHOWN), 28'd0);
        cyc();
        RST_N = 1'b1;
        cyc();
        chk("post_rst_hex", bus.HEX, ONES);
        drive(1'b1, 16'hBEEF, 1'b0);
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk($sformatf("rst_phase_%0d", i), bus.HEX,
                (i <= 4) ? mbeef : ONES);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
